// File: rtl/mau_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states,
// big-endian byte-enable patterns and the latched operation record.
package mau_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_RSVD = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_HALF = 2'b11;

  localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
  localparam logic [BE_W-1:0] BE_BYTE0   = 4'b1000;
  localparam logic [BE_W-1:0] BE_HI_HALF = 4'b1100;
  localparam logic [BE_W-1:0] BE_LO_HALF = 4'b0011;
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       is_unsigned;
    logic [1:0] offset;
  } op_t;

  // Byte offset actually used for the access: halves and words are forced down to alignment.
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_WORD: return 2'b00;
      SZ_HALF: return {lo[1], 1'b0};
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: store byte enables / lane-aligned write data,
// and load lane extraction with sign or zero extension (big-endian lanes).
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   byte_en_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_c
);

  logic [4:0]        lane_shift;
  logic [DATA_W-1:0] rdata_sh;
  logic [7:0]        lane8;
  logic [15:0]       lane16;

  assign lane_shift = {offset, 3'b000};
  // Byte offset 0 sits in bits [31:24], so shifting left brings lane k to the top.
  assign rdata_sh   = rdata << lane_shift;
  assign lane8      = rdata_sh[31:24];
  assign lane16     = offset[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    byte_en_c = BE_NONE;
    wdata_c   = '0;
    rdata_c   = '0;
    case (size)
      SZ_BYTE: begin
        byte_en_c = BE_BYTE0 >> offset;
        wdata_c   = {wdata[7:0], 24'h0} >> lane_shift;
        rdata_c   = is_unsigned ? {24'h0, lane8} : {{24{lane8[7]}}, lane8};
      end
      SZ_HALF: begin
        byte_en_c = offset[1] ? BE_LO_HALF : BE_HI_HALF;
        wdata_c   = offset[1] ? {16'h0, wdata[15:0]} : {wdata[15:0], 16'h0};
        rdata_c   = is_unsigned ? {16'h0, lane16} : {{16{lane16[15]}}, lane16};
      end
      SZ_WORD: begin
        byte_en_c = BE_WORD;
        wdata_c   = wdata;
        rdata_c   = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator with valid/ready memory handshakes and load timeout.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being forced aligned.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqUnsigned,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic              RespValid,
  output logic [DATA_W-1:0] RespData,
  output logic              Fault,
  output logic              Stall,
  output logic              MemReqValid,
  input  logic              MemReqReady,
  output logic              MemWrite,
  output logic [DATA_W-1:0] MemAddr,
  output logic [BE_W-1:0]   MemByteEn,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemRespValid,
  input  logic [DATA_W-1:0] MemRData
);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_ready_d, resp_valid_d, fault_d, stall_d;
  logic              mem_req_valid_d, mem_write_d;
  logic [DATA_W-1:0] resp_data_d, mem_addr_d, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_d;

  logic [1:0]        req_off_c, lane_size, lane_off;
  logic              misalign_c, req_fault_c;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wdata, lane_rdata;

  assign req_off_c = align_offset(ReqSize, Address[1:0]);

`ifdef MISALIGN_TRAP_EN
  assign misalign_c = ((ReqSize == SZ_HALF) && Address[0]) ||
                      ((ReqSize == SZ_WORD) && (Address[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign req_fault_c = (ReqSize == SZ_RSVD) || misalign_c;

  // Steer the lane logic from the incoming request while idle, from the latched op afterwards.
  assign lane_size = (state_q == ST_IDLE) ? ReqSize   : op_q.size;
  assign lane_off  = (state_q == ST_IDLE) ? req_off_c : op_q.offset;

  mau_lane_align u_lane_align (
    .size        (lane_size),
    .offset      (lane_off),
    .is_unsigned (op_q.is_unsigned),
    .wdata       (WriteData),
    .rdata       (MemRData),
    .byte_en_c   (lane_be),
    .wdata_c     (lane_wdata),
    .rdata_c     (lane_rdata)
  );

  // Next-state and next-output logic; every output below is the registered copy.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    cnt_d           = cnt_q;
    req_ready_d     = 1'b0;
    resp_valid_d    = 1'b0;
    resp_data_d     = '0;
    fault_d         = 1'b0;
    stall_d         = 1'b0;
    mem_req_valid_d = 1'b0;
    mem_write_d     = MemWrite;
    mem_addr_d      = MemAddr;
    mem_be_d        = MemByteEn;
    mem_wdata_d     = MemWData;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (ReqValid) begin
          op_d        = '{write: ReqWrite, size: ReqSize, is_unsigned: ReqUnsigned, offset: req_off_c};
          req_ready_d = 1'b0;
          if (req_fault_c) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            fault_d      = 1'b1;
          end else begin
            state_d         = ST_ISSUE;
            stall_d         = 1'b1;
            mem_req_valid_d = 1'b1;
            mem_write_d     = ReqWrite;
            mem_addr_d      = {Address[31:2], 2'b00};
            mem_be_d        = lane_be;
            mem_wdata_d     = lane_wdata;
          end
        end
      end
      ST_ISSUE: begin
        stall_d         = 1'b1;
        mem_req_valid_d = 1'b1;
        if (MemReqReady) begin
          mem_req_valid_d = 1'b0;
          if (op_q.write) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            stall_d      = 1'b0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        stall_d = 1'b1;
        if (MemRespValid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = lane_rdata;
          stall_d      = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            fault_d      = 1'b1;
            stall_d      = 1'b0;
          end
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      ReqReady    <= 1'b1;
      RespValid   <= 1'b0;
      RespData    <= '0;
      Fault       <= 1'b0;
      Stall       <= 1'b0;
      MemReqValid <= 1'b0;
      MemWrite    <= 1'b0;
      MemAddr     <= '0;
      MemByteEn   <= '0;
      MemWData    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      ReqReady    <= req_ready_d;
      RespValid   <= resp_valid_d;
      RespData    <= resp_data_d;
      Fault       <= fault_d;
      Stall       <= stall_d;
      MemReqValid <= mem_req_valid_d;
      MemWrite    <= mem_write_d;
      MemAddr     <= mem_addr_d;
      MemByteEn   <= mem_be_d;
      MemWData    <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations (timeout shortened to 4).
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        ReqValid, ReqReady, ReqWrite, ReqUnsigned;
  logic [1:0]  ReqSize;
  logic [31:0] Address, WriteData;
  logic        RespValid, Fault, Stall;
  logic [31:0] RespData;
  logic        MemReqValid, MemReqReady, MemWrite, MemRespValid;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic [3:0]  MemByteEn;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
    .ReqUnsigned(ReqUnsigned), .Address(Address), .WriteData(WriteData),
    .RespValid(RespValid), .RespData(RespData), .Fault(Fault), .Stall(Stall),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemWrite(MemWrite),
    .MemAddr(MemAddr), .MemByteEn(MemByteEn), .MemWData(MemWData),
    .MemRespValid(MemRespValid), .MemRData(MemRData)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqUnsigned = uns;
    Address = addr; WriteData = wd;
    tick();
    ReqValid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_data);
    issue(1'b0, sz, uns, addr, 32'h0);
    check({tag, "_mrv"}, MemReqValid, 1);
    check({tag, "_maddr"}, MemAddr, exp_addr);
    check({tag, "_be"}, MemByteEn, exp_be);
    check({tag, "_mwr"}, MemWrite, 0);
    MemReqReady = 1'b1;
    tick();
    MemReqReady = 1'b0;
    check({tag, "_mrv_drop"}, MemReqValid, 0);
    check({tag, "_stall"}, Stall, 1);
    MemRespValid = 1'b1; MemRData = rdata;
    tick();
    MemRespValid = 1'b0;
    check({tag, "_rv"}, RespValid, 1);
    check({tag, "_data"}, RespData, exp_data);
    check({tag, "_fault"}, Fault, 0);
    check({tag, "_stall_off"}, Stall, 0);
    tick();
    check({tag, "_rv_off"}, RespValid, 0);
    check({tag, "_ready"}, ReqReady, 1);
  endtask

  initial begin
    Rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqUnsigned = 1'b0;
    Address = '0; WriteData = '0; MemReqReady = 1'b0; MemRespValid = 1'b0; MemRData = '0;
    #12;
    check("rst_ready", ReqReady, 1);
    check("rst_rv", RespValid, 0);
    check("rst_mrv", MemReqValid, 0);
    check("rst_stall", Stall, 0);
    check("rst_be", MemByteEn, 0);
    check("rst_fault", Fault, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    // 1: lb @0x103, sign-extended lane 3
    run_load("lb", 2'b10, 1'b0, 32'h0000_0103, 32'h1122_33F5, 32'h0000_0100, 4'b0001, 32'hFFFF_FFF5);
    // 2: lhu / lh @0x202, low half
    run_load("lhu", 2'b11, 1'b1, 32'h0000_0202, 32'h0000_8001, 32'h0000_0200, 4'b0011, 32'h0000_8001);
    run_load("lh", 2'b11, 1'b0, 32'h0000_0202, 32'h0000_8001, 32'h0000_0200, 4'b0011, 32'hFFFF_8001);
    // lbu at offset 0 and lh upper half
    run_load("lbu0", 2'b10, 1'b1, 32'h0000_0600, 32'h80FF_0000, 32'h0000_0600, 4'b1000, 32'h0000_0080);
    run_load("lhhi", 2'b11, 1'b0, 32'h0000_0700, 32'h9234_5678, 32'h0000_0700, 4'b1100, 32'hFFFF_9234);

    // 3: sb 0xAB @0x301 with three refused cycles
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0301, 32'h0000_00AB);
    for (int i = 0; i < 3; i++) begin
      check("sb_hold_mrv", MemReqValid, 1);
      check("sb_hold_rv", RespValid, 0);
      tick();
    end
    MemReqReady = 1'b1;
    check("sb_mrv4", MemReqValid, 1);
    check("sb_be", MemByteEn, 4'b0100);
    check("sb_lane", MemWData[23:16], 8'hAB);
    check("sb_mwr", MemWrite, 1);
    check("sb_addr", MemAddr, 32'h0000_0300);
    tick();
    MemReqReady = 1'b0;
    check("sb_rv", RespValid, 1);
    check("sb_mrv_off", MemReqValid, 0);
    check("sb_data", RespData, 0);
    check("sb_stall_off", Stall, 0);
    check("sb_ready_resp", ReqReady, 0);
    tick();
    check("sb_rv_off", RespValid, 0);

    // sh to upper half, immediate handshake
    issue(1'b1, 2'b11, 1'b0, 32'h0000_0310, 32'hFFFF_BEEF);
    check("sh_be", MemByteEn, 4'b1100);
    check("sh_wdata", MemWData, 32'hBEEF_0000);
    MemReqReady = 1'b1;
    tick();
    MemReqReady = 1'b0;
    check("sh_rv", RespValid, 1);
    tick();

    // 4: lw @0x402
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0402, 32'h0);
    check("lwmis_rv", RespValid, 1);
    check("lwmis_fault", Fault, 1);
    check("lwmis_mrv", MemReqValid, 0);
    check("lwmis_data", RespData, 0);
    tick();
    check("lwmis_ready", ReqReady, 1);
    check("lwmis_mrv2", MemReqValid, 0);
`else
    run_load("lwmis", 2'b00, 1'b1, 32'h0000_0402, 32'hDEAD_BEEF, 32'h0000_0400, 4'b1111, 32'hDEAD_BEEF);
`endif

    // Reserved size always faults without touching memory
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0800, 32'h0);
    check("rsvd_rv", RespValid, 1);
    check("rsvd_fault", Fault, 1);
    check("rsvd_mrv", MemReqValid, 0);
    tick();

    // 5: lw with no memory response -> timeout after 4 WAIT cycles
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0500, 32'h0);
    MemReqReady = 1'b1;
    tick();
    MemReqReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_rv", RespValid, 0);
      check("to_wait_stall", Stall, 1);
    end
    tick();
    check("to_rv", RespValid, 1);
    check("to_fault", Fault, 1);
    check("to_data", RespData, 0);
    check("to_stall", Stall, 0);
    tick();
    check("to_rv_off", RespValid, 0);
    check("to_fault_off", Fault, 0);

    // 6: reset while in WAIT, then a stray memory response
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0900, 32'h0);
    MemReqReady = 1'b1;
    tick();
    MemReqReady = 1'b0;
    check("rw_stall", Stall, 1);
    Rst_n = 1'b0;
    #2;
    check("rw_ready", ReqReady, 1);
    check("rw_stall_rst", Stall, 0);
    tick();
    Rst_n = 1'b1;
    tick();
    MemRespValid = 1'b1; MemRData = 32'h1234_5678;
    tick();
    MemRespValid = 1'b0;
    check("rw_no_rv", RespValid, 0);
    check("rw_ready2", ReqReady, 1);
    run_load("rw_next", 2'b00, 1'b0, 32'h0000_0A00, 32'hCAFE_F00D, 32'h0000_0A00, 4'b1111, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
